led_fb_writer: RTL

//  Write side of the 2048x24 dual-port framebuffer that the HUB75 panel scanner reads.

---
 rtl/led_fb_writer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/led_fb_writer.sv
// Write port of the HUB75 framebuffer: executes PLOT, 3x3 BRUSH, FILL and NOP
// paint commands, with read-modify-write so only one half of each word changes.
module led_fb_writer #(
    parameter int NUM_COLS  = 64,
    parameter int NUM_ROWS  = 64,
    parameter int BIT_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [1:0]                            cmd_op,
    input  logic [$clog2(NUM_COLS)-1:0]           cmd_x,
    input  logic [$clog2(NUM_ROWS)-1:0]           cmd_y,
    input  logic [3*BIT_DEPTH-1:0]                cmd_color,
    output logic [$clog2(NUM_COLS)+$clog2(NUM_ROWS)-2:0] mem_addr,
    output logic                                  mem_re,
    input  logic [6*BIT_DEPTH-1:0]                mem_rdata,
    output logic                                  mem_we,
    output logic [6*BIT_DEPTH-1:0]                mem_wdata,
    output logic                                  busy,
    output logic                                  done
);
    localparam int XW    = $clog2(NUM_COLS);
    localparam int YW    = $clog2(NUM_ROWS);
    localparam int AW    = XW + YW - 1;
    localparam int PIX_W = 3 * BIT_DEPTH;

    localparam logic [1:0] OP_PLOT  = 2'b00;
    localparam logic [1:0] OP_BRUSH = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;

    // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, so inputs are ignored while a command runs.
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_SKIP, S_FILL, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [PIX_W-1:0] color_q, color_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             half_q, half_d;
    logic [1:0]       bx_q, bx_d, by_q, by_d;

    logic [1:0]       nbx, nby;
    logic             last_pt;
    logic [AW+1:0]    pt_first, pt_next;

    // Returns {in_range, half, word_addr} for brush offset (ox-1, oy-1) around (cx, cy).
    function automatic logic [AW+1:0] brush_pt(input logic [XW-1:0] cx, input logic [YW-1:0] cy,
                                               input logic [1:0] ox, input logic [1:0] oy);
        int   px, py;
        logic ok;
        px = int'(cx) + int'(ox) - 1;
        py = int'(cy) + int'(oy) - 1;
        ok = (px >= 0) && (px < NUM_COLS) && (py >= 0) && (py < NUM_ROWS);
        return {ok, py[YW-1], py[YW-2:0], px[XW-1:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b11;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            addr_q  <= '0;
            half_q  <= 1'b0;
            bx_q    <= 2'd0;
            by_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            addr_q  <= addr_d;
            half_q  <= half_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        addr_d  = addr_q;
        half_d  = half_q;
        bx_d    = bx_q;
        by_d    = by_q;

        nbx      = (bx_q == 2'd2) ? 2'd0 : bx_q + 2'd1;
        nby      = (bx_q == 2'd2) ? by_q + 2'd1 : by_q;
        last_pt  = (bx_q == 2'd2) && (by_q == 2'd2);
        pt_first = brush_pt(cmd_x, cmd_y, 2'd0, 2'd0);
        pt_next  = brush_pt(x_q, y_q, nbx, nby);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    color_d = cmd_color;
                    case (cmd_op)
                        OP_PLOT: begin
                            addr_d  = {cmd_y[YW-2:0], cmd_x};
                            half_d  = cmd_y[YW-1];
                            state_d = S_RD;
                        end
                        OP_BRUSH: begin
                            bx_d    = 2'd0;
                            by_d    = 2'd0;
                            state_d = pt_first[AW+1] ? S_RD : S_SKIP;
                            if (pt_first[AW+1]) begin
                                addr_d = pt_first[AW-1:0];
                                half_d = pt_first[AW];
                            end
                        end
                        OP_FILL: begin
                            addr_d  = '0;
                            state_d = S_FILL;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_RD: state_d = S_WR;
            S_WR, S_SKIP: begin
                if (op_q == OP_BRUSH && !last_pt) begin
                    bx_d    = nbx;
                    by_d    = nby;
                    state_d = pt_next[AW+1] ? S_RD : S_SKIP;
                    if (pt_next[AW+1]) begin
                        addr_d = pt_next[AW-1:0];
                        half_d = pt_next[AW];
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            S_FILL: begin
                if (addr_q == {AW{1'b1}}) state_d = S_DONE;
                else                      addr_d  = addr_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = ~cmd_ready;
    assign done      = (state_q == S_DONE);
    assign mem_re    = (state_q == S_RD);
    assign mem_we    = (state_q == S_WR) || (state_q == S_FILL);
    assign mem_addr  = addr_q;

    // Read data arrives during WR; splice the colour into the selected half only.
    always_comb begin
        mem_wdata = '0;
        if (state_q == S_WR)
            mem_wdata = half_q ? {mem_rdata[2*PIX_W-1:PIX_W], color_q}
                               : {color_q, mem_rdata[PIX_W-1:0]};
        else if (state_q == S_FILL)
            mem_wdata = {color_q, color_q};
    end

endmodule
